channel_output: RTL

CHANNEL_OUTPUT -- requirements
Module: channel_output

---
 rtl/channel_output.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/channel_output.sv
// Channel send engine: reads a channel word, then rendezvous with a waiting receiver
// or parks the sender's pid and message in the channel, and reports scheduling results.
module channel_output #(
    parameter int unsigned addrBits = 8,
    parameter int unsigned dataBits = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enabled,
    output logic                finished,
    output logic [addrBits-1:0] address,
    output logic                readWriteMode,
    output logic [dataBits-1:0] dataIn,
    input  logic [dataBits-1:0] dataOut,
    input  logic [addrBits-1:0] channel,
    input  logic [addrBits-1:0] txPid,
    input  logic [dataBits-1:0] message,
    output logic                shouldDescheduleSender,
    output logic                shouldScheduleReceiver,
    output logic                hasDeliveredMessage,
    output logic                protocolError,
    output logic [addrBits-1:0] scheduleRxPid,
    output logic [dataBits-1:0] deliveredMessage
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StRead     = 3'd1;
    localparam logic [2:0] StWait     = 3'd2;
    localparam logic [2:0] StWritePid = 3'd3;
    localparam logic [2:0] StWriteMsg = 3'd4;
    localparam logic [2:0] StClear    = 3'd5;
    localparam logic [2:0] StDone     = 3'd6;

    logic [2:0]          stateQ, stateD;
    logic [addrBits-1:0] chanQ;
    logic [addrBits-1:0] pidQ;
    logic [dataBits-1:0] msgQ;

    logic                descheduleQ;
    logic                scheduleQ;
    logic                deliveredQ;
    logic                errorQ;
    logic [addrBits-1:0] rxPidQ;
    logic [dataBits-1:0] delMsgQ;

    // Channel word decode, only meaningful in StWait when dataOut holds the channel word.
    logic [addrBits-1:0] waitPid;
    logic                chanEmpty;
    logic                altWaiting;
    logic                isAlt;
    logic                isError;
    logic                isRx;
    logic [dataBits-1:0] pidWord;

    assign waitPid    = dataOut[addrBits-1:0];
    assign chanEmpty  = (dataOut == '0);
    assign altWaiting = dataOut[dataBits-1];
    assign isAlt      = !chanEmpty && altWaiting;
    assign isError    = !chanEmpty && !altWaiting && (waitPid == pidQ);
    assign isRx       = !chanEmpty && !altWaiting && (waitPid != pidQ);

    always_comb begin
        pidWord = '0;
        pidWord[addrBits-1:0] = pidQ;
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle:     if (enabled) stateD = StRead;
            StRead:     stateD = StWait;
            StWait: begin
                if (chanEmpty || altWaiting) begin
                    stateD = StWritePid;
                end else if (isError) begin
                    stateD = StDone;
                end else begin
                    stateD = StClear;
                end
            end
            StWritePid: stateD = StWriteMsg;
            StWriteMsg: stateD = StDone;
            StClear:    stateD = StDone;
            StDone:     if (!enabled) stateD = StIdle;
            default:    stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ      <= StIdle;
            chanQ       <= '0;
            pidQ        <= '0;
            msgQ        <= '0;
            descheduleQ <= 1'b0;
            scheduleQ   <= 1'b0;
            deliveredQ  <= 1'b0;
            errorQ      <= 1'b0;
            rxPidQ      <= '0;
            delMsgQ     <= '0;
        end else begin
            stateQ <= stateD;
            if (stateQ == StIdle && enabled) begin
                chanQ       <= channel;
                pidQ        <= txPid;
                msgQ        <= message;
                descheduleQ <= 1'b0;
                scheduleQ   <= 1'b0;
                deliveredQ  <= 1'b0;
                errorQ      <= 1'b0;
                rxPidQ      <= '0;
                delMsgQ     <= '0;
            end
            // Results are fixed at decode time; the write states only touch memory.
            if (stateQ == StWait) begin
                descheduleQ <= chanEmpty || isAlt;
                scheduleQ   <= isAlt || isRx;
                deliveredQ  <= isRx;
                errorQ      <= isError;
                rxPidQ      <= (isAlt || isRx) ? waitPid : '0;
                delMsgQ     <= isRx ? msgQ : '0;
            end
        end
    end

    // Outputs are forced low while reset is held so no memory write can slip through.
    always_comb begin
        finished               = 1'b0;
        address                = '0;
        readWriteMode          = 1'b0;
        dataIn                 = '0;
        shouldDescheduleSender = 1'b0;
        shouldScheduleReceiver = 1'b0;
        hasDeliveredMessage    = 1'b0;
        protocolError          = 1'b0;
        scheduleRxPid          = '0;
        deliveredMessage       = '0;
        if (!reset) begin
            unique case (stateQ)
                StRead, StWait: address = chanQ;
                StWritePid: begin
                    address       = chanQ;
                    readWriteMode = 1'b1;
                    dataIn        = pidWord;
                end
                StWriteMsg: begin
                    address       = chanQ + addrBits'(1);
                    readWriteMode = 1'b1;
                    dataIn        = msgQ;
                end
                StClear: begin
                    address       = chanQ;
                    readWriteMode = 1'b1;
                end
                StDone: begin
                    finished               = 1'b1;
                    shouldDescheduleSender = descheduleQ;
                    shouldScheduleReceiver = scheduleQ;
                    hasDeliveredMessage    = deliveredQ;
                    protocolError          = errorQ;
                    scheduleRxPid          = rxPidQ;
                    deliveredMessage       = delMsgQ;
                end
                default: ;
            endcase
        end
    end

endmodule
